// File: rtl/ls_agu_stage.sv
// Load/store address generation: selects and sign-extends the immediate, adds the base,
// flags misaligned accesses, and registers the result into a 2-entry skid buffer.
module ls_agu_stage #(
    parameter int XLEN  = 32,
    parameter int IMM_W = 12,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_is_store,
    input  logic [IMM_W-1:0] in_load_imm,
    input  logic [IMM_W-1:0] in_store_imm,
    input  logic [XLEN-1:0]  in_base,
    input  logic [1:0]       in_size,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_addr,
    output logic [XLEN-1:0]  out_offset,
    output logic             out_is_store,
    output logic [1:0]       out_size,
    output logic             out_misaligned,
    output logic [CNT_W-1:0] misalign_cnt
);
    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] offset;
        logic            isStore;
        logic [1:0]      size;
        logic            misaligned;
    } aguEntry_t;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [1:0]       state;
    aguEntry_t        head, skid, newEntry;
    logic [IMM_W-1:0] imm;
    logic             accept, deliver;

    always_comb begin
        imm                 = in_is_store ? in_store_imm : in_load_imm;
        newEntry.offset     = {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm};
        newEntry.addr       = in_base + newEntry.offset;
        newEntry.isStore    = in_is_store;
        newEntry.size       = in_size;
        newEntry.misaligned = 1'b0;
        unique case (in_size)
            2'd0:    newEntry.misaligned = 1'b0;
            2'd1:    newEntry.misaligned = newEntry.addr[0];
            2'd2:    newEntry.misaligned = |newEntry.addr[1:0];
            default: newEntry.misaligned = (XLEN == 64) ? |newEntry.addr[2:0] : 1'b1;
        endcase
    end

    // Handshake flags decode straight from the state register, so in_ready never sees out_ready.
    assign in_ready  = (state != TWO);
    assign out_valid = (state != EMPTY);
    assign accept    = in_valid & in_ready;
    assign deliver   = out_valid & out_ready;

    assign out_addr       = head.addr;
    assign out_offset     = head.offset;
    assign out_is_store   = head.isStore;
    assign out_size       = head.size;
    assign out_misaligned = head.misaligned;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= EMPTY;
            head         <= '0;
            skid         <= '0;
            misalign_cnt <= '0;
        end else begin
            // A delivery still happens in a flush cycle, so it is counted regardless.
            if (deliver && head.misaligned && misalign_cnt != CNT_MAX)
                misalign_cnt <= misalign_cnt + 1'b1;
            if (flush) begin
                state <= EMPTY;
            end else begin
                unique case (state)
                    EMPTY: if (accept) begin
                        head  <= newEntry;
                        state <= ONE;
                    end
                    ONE: begin
                        if (accept && deliver) begin
                            head <= newEntry;
                        end else if (accept) begin
                            skid  <= newEntry;
                            state <= TWO;
                        end else if (deliver) begin
                            state <= EMPTY;
                        end
                    end
                    TWO: if (deliver) begin
                        head  <= skid;
                        state <= ONE;
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule
